game_state_poller: RTL and testbench
====================================

# game_state_poller

Parametrised game-state sequencer that sits between the processor's data/video memory read port and the screen drawer. It sweeps a memory-mapped status window round-robin and commits player lives, player positions and correct-door codes atomically as one snapshot. It also runs the round timer with its timed pause and resume. It generalises fixed two-player polling to N players, configurable addresses and read latency, and frozen positions during the reveal pause.

## Interface
- N_PLAYERS, 2: players; 1..8; requires 2*N_PLAYERS <= DATA_W
- ADDR_W, 32: read address width
- DATA_W, 32: read data width
- BASE_ADDR, 32'h0000_6000: first status word
- STRIDE, 32'h0000_1000: address step between status words
- RD_LAT, 1: memory read latency in cycles, 1..4
- CLK_HZ, 25_000_000: clk cycles per second
- ROUND_SEC, 10: round length in seconds, 1..255
- PAUSE_SEC, 1: reveal pause in seconds, 1..15
- clk  in  1  pixel-domain clock (VGA_CLK)
- reset  in  1  asynchronous, active-low reset
- enable  in  1  timer advance enable; sweeps run regardless
- restart  in  1  synchronous pulse: new round without resume
- rd_addr  out  ADDR_W  registered read address
- rd_data  in  DATA_W  read data, valid RD_LAT cycles after rd_addr
- lives  out  N_PLAYERS x 2  committed lives per player
- pos  out  N_PLAYERS x 2  committed door position per player
- door  out  N_PLAYERS x 2  committed correct door per player
- snap_valid  out  1  one-cycle pulse on each commit
- seconds  out  8  elapsed seconds in current round
- time_up  out  1  high during reveal pause
- resume  out  1  one-cycle pulse at pause end
- round_cnt  out  8  completed rounds, wraps 255 -> 0

## Operation
- Word map: lives k at BASE+k*STRIDE; door word at BASE+N*STRIDE; pos k at BASE+(N+1+k)*STRIDE. Total M = 2N+1 words. Field value = rd_data[1:0]. Door k = door word bits [2k+1:2k].
- Sweep FSM states:
  - ISSUE: drive word i address.
  - WAIT: RD_LAT-1 cycles; skipped when RD_LAT=1.
  - CAPTURE: load the shadow register for word i; i++. Go to COMMIT if i==M, else ISSUE.
  - COMMIT: copy shadows to outputs; pulse snap_valid; i=0; go to ISSUE.
- Sweep period = M*(RD_LAT+1)+1 cycles.
- Commit while time_up=1: lives and door update, pos holds its pre-pause value.
- Timer FSM states:
  - RUN: prescaler counts 0..CLK_HZ-1 while enable=1 and holds while enable=0. Wrap increments seconds. When seconds reaches ROUND_SEC, go to PAUSE; time_up=1 from the next cycle; seconds holds at ROUND_SEC.
  - PAUSE: counts PAUSE_SEC*CLK_HZ cycles, ignoring enable. On the last count: resume=1 for one cycle, time_up=0, seconds=0, prescaler=0, round_cnt++, return to RUN.
- restart=1 in any state: go to RUN, seconds=0, prescaler=0, time_up=0. No resume pulse, round_cnt unchanged. It has priority over a simultaneous pause end.
- Reset, including mid-sweep or mid-pause:
  - rd_addr=BASE_ADDR, i=0, sweep FSM=ISSUE.
  - lives, pos, door, shadows = 0.
  - snap_valid=0, seconds=0, time_up=0, resume=0, round_cnt=0, timer FSM=RUN.
  - No partial snapshot is ever committed.

## Timing
- All outputs are registered, with no combinational path from any input to any output.
- Data sampled in CAPTURE is the data for the address issued RD_LAT cycles earlier.
- The first snap_valid after reset release occurs at cycle M*(RD_LAT+1)+1.
- A memory write is visible in the outputs within 2 sweep periods plus 1 cycle.
- time_up rises 1 cycle after the prescaler wrap that makes seconds==ROUND_SEC.
- resume and the time_up fall occur in the same cycle.

## Structure
- Package game_pkg holds:
  - sweep_state_t {ISSUE, WAIT, CAPTURE, COMMIT}
  - timer_state_t {RUN, PAUSE}
  - typedef field2_t = logic [1:0]
  - word index function returning the address of word i
- Sub-module round_timer: the timer FSM with prescaler and pause counter. The sweep sequencer is instantiated in the top.

## Test plan
1. Memory model with RD_LAT=1, N=2, lives {3,2}, door word 4'b1100, pos {1,2}:
   - snap_valid first at cycle 11.
   - lives={3,2}, door={0,3}, pos={1,2}.
   - Addresses appear in order 6000, 7000, 8000, 9000, A000.
2. RD_LAT=3, N=4 with a distinct value per word: every field lands in the correct slot, and the sweep period is 37 cycles.
3. CLK_HZ=4, ROUND_SEC=3, PAUSE_SEC=1:
   - time_up rises at cycle 13.
   - resume pulses at cycle 17; seconds=0; round_cnt=1.
4. Change pos in memory during PAUSE: pos holds, while lives changed in the same pause does update. After resume, the new pos commits within 2 sweeps.
5. enable=0 for 6 cycles mid-round: seconds frozen, round ends 6 cycles later. restart in the same cycle as pause end: no resume pulse, round_cnt unchanged.
6. Assert reset mid-CAPTURE and mid-PAUSE: all outputs return to reset values immediately (asynchronously), and the sequence restarts cleanly.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and address helper for the game-state poller.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package game_pkg;

    typedef enum logic [1:0] {ISSUE, WAIT, CAPTURE, COMMIT} sweep_state_t;
    typedef enum logic {RUN, PAUSE} timer_state_t;
    typedef logic [1:0] field2_t;

    // Byte address of status word i in the polled window.
    function automatic logic [63:0] word_addr(input logic [63:0] base,
                                              input logic [63:0] stride,
                                              input logic [31:0] i);
        return base + stride * 64'(i);
    endfunction

endpackage

// File: rtl/round_timer.sv
// Round timer: seconds prescaler, round-end detection, timed reveal pause and resume.
// Latency: time_up rises one cycle after the wrap reaching ROUND_SEC; resume/time_up fall together.
// Backpressure: none; enable only gates the prescaler in RUN, restart overrides everything.
module round_timer
    import game_pkg::*;
#(
    parameter int CLK_HZ    = 25_000_000,
    parameter int ROUND_SEC = 10,
    parameter int PAUSE_SEC = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       restart,
    output logic [7:0] seconds,
    output logic       time_up,
    output logic       resume,
    output logic [7:0] round_cnt
);

    localparam int PAUSE_CYC = PAUSE_SEC * CLK_HZ;
    localparam int PW        = $clog2(CLK_HZ + 1);
    localparam int QW        = $clog2(PAUSE_CYC + 1);

    timer_state_t  state, state_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic [QW-1:0] pcnt, pcnt_nxt;
    logic [7:0]    seconds_nxt, round_cnt_nxt;
    logic          time_up_nxt, resume_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            presc     <= '0;
            pcnt      <= '0;
            seconds   <= '0;
            time_up   <= 1'b0;
            resume    <= 1'b0;
            round_cnt <= '0;
        end else begin
            state     <= state_nxt;
            presc     <= presc_nxt;
            pcnt      <= pcnt_nxt;
            seconds   <= seconds_nxt;
            time_up   <= time_up_nxt;
            resume    <= resume_nxt;
            round_cnt <= round_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        presc_nxt     = presc;
        pcnt_nxt      = pcnt;
        seconds_nxt   = seconds;
        time_up_nxt   = time_up;
        resume_nxt    = 1'b0;
        round_cnt_nxt = round_cnt;
        // restart wins over a pause end landing in the same cycle
        if (restart) begin
            state_nxt   = RUN;
            presc_nxt   = '0;
            pcnt_nxt    = '0;
            seconds_nxt = '0;
            time_up_nxt = 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (seconds == 8'(ROUND_SEC)) begin
                        state_nxt   = PAUSE;
                        time_up_nxt = 1'b1;
                        pcnt_nxt    = '0;
                    end else if (enable) begin
                        if (presc == PW'(CLK_HZ - 1)) begin
                            presc_nxt   = '0;
                            seconds_nxt = seconds + 8'd1;
                        end else begin
                            presc_nxt = presc + PW'(1);
                        end
                    end
                end
                PAUSE: begin
                    if (pcnt == QW'(PAUSE_CYC - 1)) begin
                        state_nxt     = RUN;
                        time_up_nxt   = 1'b0;
                        resume_nxt    = 1'b1;
                        seconds_nxt   = '0;
                        presc_nxt     = '0;
                        round_cnt_nxt = round_cnt + 8'd1;
                    end else begin
                        pcnt_nxt = pcnt + QW'(1);
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

endmodule

// File: rtl/game_state_poller.sv
// Sweeps the status window round-robin and commits lives/pos/door as one snapshot; hosts the round timer.
// Latency: sweep period M*(RD_LAT+1)+1 cycles, first snap_valid at that cycle after reset release.
// Backpressure: none; fixed-latency read port, outputs simply update on each commit.
module game_state_poller
    import game_pkg::*;
#(
    parameter int                N_PLAYERS = 2,
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h0000_6000),
    parameter logic [ADDR_W-1:0] STRIDE    = ADDR_W'(32'h0000_1000),
    parameter int                RD_LAT    = 1,
    parameter int                CLK_HZ    = 25_000_000,
    parameter int                ROUND_SEC = 10,
    parameter int                PAUSE_SEC = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   restart,
    output logic [ADDR_W-1:0]      rd_addr,
    input  logic [DATA_W-1:0]      rd_data,
    output logic [2*N_PLAYERS-1:0] lives,
    output logic [2*N_PLAYERS-1:0] pos,
    output logic [2*N_PLAYERS-1:0] door,
    output logic                   snap_valid,
    output logic [7:0]             seconds,
    output logic                   time_up,
    output logic                   resume,
    output logic [7:0]             round_cnt
);

    localparam int M  = 2 * N_PLAYERS + 1;
    localparam int IW = $clog2(M + 1);
    localparam int WW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int FW = 2 * N_PLAYERS;

    sweep_state_t      state, state_nxt;
    logic [IW-1:0]     idx, idx_nxt;
    logic [WW-1:0]     wcnt, wcnt_nxt;
    logic [ADDR_W-1:0] rd_addr_nxt;
    logic [FW-1:0]     sh_lives, sh_lives_nxt, sh_pos, sh_pos_nxt, sh_door, sh_door_nxt;
    logic [FW-1:0]     lives_nxt, pos_nxt, door_nxt;
    logic              snap_nxt;
    logic              unused_rd_bits;

    // Only the low field bits of each word are meaningful.
    assign unused_rd_bits = ^rd_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ISSUE;
            idx        <= '0;
            wcnt       <= '0;
            rd_addr    <= BASE_ADDR;
            sh_lives   <= '0;
            sh_pos     <= '0;
            sh_door    <= '0;
            lives      <= '0;
            pos        <= '0;
            door       <= '0;
            snap_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            wcnt       <= wcnt_nxt;
            rd_addr    <= rd_addr_nxt;
            sh_lives   <= sh_lives_nxt;
            sh_pos     <= sh_pos_nxt;
            sh_door    <= sh_door_nxt;
            lives      <= lives_nxt;
            pos        <= pos_nxt;
            door       <= door_nxt;
            snap_valid <= snap_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        wcnt_nxt     = wcnt;
        rd_addr_nxt  = rd_addr;
        sh_lives_nxt = sh_lives;
        sh_pos_nxt   = sh_pos;
        sh_door_nxt  = sh_door;
        lives_nxt    = lives;
        pos_nxt      = pos;
        door_nxt     = door;
        snap_nxt     = 1'b0;
        case (state)
            ISSUE: begin
                wcnt_nxt  = '0;
                state_nxt = (RD_LAT == 1) ? CAPTURE : WAIT;
            end
            WAIT: begin
                if (wcnt == WW'(RD_LAT - 2)) state_nxt = CAPTURE;
                else                         wcnt_nxt  = wcnt + WW'(1);
            end
            CAPTURE: begin
                for (int k = 0; k < N_PLAYERS; k++) begin
                    if (32'(idx) == 32'(k))
                        sh_lives_nxt[2*k +: 2] = rd_data[1:0];
                    if (32'(idx) == 32'(N_PLAYERS + 1 + k))
                        sh_pos_nxt[2*k +: 2] = rd_data[1:0];
                end
                if (32'(idx) == 32'(N_PLAYERS))
                    sh_door_nxt = rd_data[FW-1:0];
                // Address for the next word is set here so it is stable through ISSUE/WAIT.
                if (32'(idx) == 32'(M - 1)) begin
                    idx_nxt     = '0;
                    state_nxt   = COMMIT;
                    rd_addr_nxt = BASE_ADDR;
                end else begin
                    idx_nxt     = idx + IW'(1);
                    state_nxt   = ISSUE;
                    rd_addr_nxt = ADDR_W'(word_addr(64'(BASE_ADDR), 64'(STRIDE), 32'(idx) + 32'd1));
                end
            end
            COMMIT: begin
                lives_nxt = sh_lives;
                door_nxt  = sh_door;
                // Positions stay frozen while the correct door is being revealed.
                if (!time_up) pos_nxt = sh_pos;
                snap_nxt  = 1'b1;
                state_nxt = ISSUE;
            end
            default: state_nxt = ISSUE;
        endcase
    end

    round_timer #(
        .CLK_HZ    (CLK_HZ),
        .ROUND_SEC (ROUND_SEC),
        .PAUSE_SEC (PAUSE_SEC)
    ) u_round_timer (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .restart   (restart),
        .seconds   (seconds),
        .time_up   (time_up),
        .resume    (resume),
        .round_cnt (round_cnt)
    );

endmodule

// File: tb/tb_game_state_poller.sv
// Directed bench: small N=2/RD_LAT=1 instance with a fast timer, plus an N=4/RD_LAT=3 instance.
`timescale 1ns/1ps
module tb_game_state_poller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, enable, restart;

    logic [31:0] rd_addr_a, rd_data_a;
    logic [3:0]  lives_a, pos_a, door_a;
    logic        snap_a, tu_a, res_a;
    logic [7:0]  sec_a, rc_a;

    logic [31:0] rd_addr_b, rd_data_b;
    logic [7:0]  lives_b, pos_b, door_b;
    logic        snap_b, tu_b, res_b;
    logic [7:0]  sec_b, rc_b;

    logic [31:0] mem_a [5];
    logic [31:0] mem_b [9];
    logic [31:0] pipe_b [3];
    logic [31:0] addr_exp [5];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    game_state_poller #(
        .N_PLAYERS(2), .RD_LAT(1), .CLK_HZ(4), .ROUND_SEC(3), .PAUSE_SEC(1)
    ) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .restart(restart),
        .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .lives(lives_a), .pos(pos_a), .door(door_a), .snap_valid(snap_a),
        .seconds(sec_a), .time_up(tu_a), .resume(res_a), .round_cnt(rc_a)
    );

    game_state_poller #(
        .N_PLAYERS(4), .RD_LAT(3)
    ) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .restart(restart),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .lives(lives_b), .pos(pos_b), .door(door_b), .snap_valid(snap_b),
        .seconds(sec_b), .time_up(tu_b), .resume(res_b), .round_cnt(rc_b)
    );

    function automatic logic [31:0] rd_a(input logic [31:0] a);
        logic [31:0] k;
        k = (a - 32'h6000) >> 12;
        return (k < 32'd5) ? mem_a[k[2:0]] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] rd_b(input logic [31:0] a);
        logic [31:0] k;
        k = (a - 32'h6000) >> 12;
        return (k < 32'd9) ? mem_b[k[3:0]] : 32'hDEAD_BEEF;
    endfunction

    // Memory models: 1-cycle read for A, 3-stage pipelined read for B.
    always @(posedge clk) begin
        rd_data_a <= rd_a(rd_addr_a);
        pipe_b[0] <= rd_b(rd_addr_b);
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign rd_data_b = pipe_b[2];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        reset   = 1'b0;
        enable  = 1'b1;
        restart = 1'b0;
        addr_exp = '{32'h6000, 32'h7000, 32'h8000, 32'h9000, 32'hA000};
        mem_a = '{32'h0000_00F3, 32'h0000_0002, 32'h0000_000C, 32'h0000_0001, 32'h0000_0002};
        mem_b = '{32'h1234_5671, 32'hFFFF_FFF2, 32'h0000_0003, 32'h8000_0000, 32'hABCD_EF9C,
                  32'h0000_0012, 32'hFFFF_FFFC, 32'h5555_5555, 32'h0000_0007};

        // Phase 1: sweep order, first snapshot, round timing, frozen positions during pause.
        do_reset();
        chk_eq("rst_addr",  rd_addr_a, 32'h6000);
        chk_eq("rst_lives", 32'(lives_a), 32'h0);
        chk_eq("rst_pos",   32'(pos_a), 32'h0);
        chk_eq("rst_door",  32'(door_a), 32'h0);
        chk_eq("rst_snap",  32'(snap_a), 32'h0);
        chk_eq("rst_sec",   32'(sec_a), 32'h0);
        chk_eq("rst_tu",    32'(tu_a), 32'h0);
        chk_eq("rst_rc",    32'(rc_a), 32'h0);
        while (cyc < 75) begin
            tick();
            if (cyc >= 2 && cyc <= 8 && cyc % 2 == 0) chk_eq("addr_seq", rd_addr_a, addr_exp[cyc/2]);
            if (cyc == 10) begin
                chk_eq("addr_wrap", rd_addr_a, addr_exp[0]);
                chk_eq("snap_pre", 32'(snap_a), 32'h0);
            end
            if (cyc == 11) begin
                chk_eq("snap_first", 32'(snap_a), 32'h1);
                chk_eq("lives1", 32'(lives_a), 32'hB);
                chk_eq("door1",  32'(door_a), 32'hC);
                chk_eq("pos1",   32'(pos_a), 32'h9);
            end
            if (cyc == 12) begin
                chk_eq("snap_pulse", 32'(snap_a), 32'h0);
                chk_eq("sec_end", 32'(sec_a), 32'h3);
                chk_eq("tu_pre", 32'(tu_a), 32'h0);
            end
            if (cyc == 13) chk_eq("tu_rise", 32'(tu_a), 32'h1);
            if (cyc == 16) begin
                chk_eq("res_pre", 32'(res_a), 32'h0);
                chk_eq("tu_hold", 32'(tu_a), 32'h1);
            end
            if (cyc == 17) begin
                chk_eq("resume", 32'(res_a), 32'h1);
                chk_eq("tu_fall", 32'(tu_a), 32'h0);
                chk_eq("sec_clr", 32'(sec_a), 32'h0);
                chk_eq("rc1", 32'(rc_a), 32'h1);
            end
            if (cyc == 18) chk_eq("res_pulse", 32'(res_a), 32'h0);
            if (cyc == 22) begin
                chk_eq("lives22", 32'(lives_a), 32'hB);
                mem_a[0] = 32'h0000_0001;
                mem_a[3] = 32'h0000_0003;
                mem_a[4] = 32'h0000_0000;
            end
            if (cyc == 30) chk_eq("tu_r2", 32'(tu_a), 32'h1);
            if (cyc == 33) begin
                chk_eq("snap33", 32'(snap_a), 32'h1);
                chk_eq("tu33", 32'(tu_a), 32'h1);
                chk_eq("lives_pause", 32'(lives_a), 32'h9);
                chk_eq("pos_frozen", 32'(pos_a), 32'h9);
                chk_eq("door_pause", 32'(door_a), 32'hC);
            end
            if (cyc == 34) chk_eq("rc2", 32'(rc_a), 32'h2);
            if (cyc == 44) begin
                chk_eq("snap44", 32'(snap_a), 32'h1);
                chk_eq("pos_after", 32'(pos_a), 32'h3);
            end
            if (cyc == 36) chk_eq("b_snap_pre", 32'(snap_b), 32'h0);
            if (cyc == 37) begin
                chk_eq("b_snap", 32'(snap_b), 32'h1);
                chk_eq("b_lives", 32'(lives_b), 32'h39);
                chk_eq("b_door",  32'(door_b), 32'h9C);
                chk_eq("b_pos",   32'(pos_b), 32'hD2);
            end
            if (cyc == 38) chk_eq("b_snap_pulse", 32'(snap_b), 32'h0);
            if (cyc == 73) chk_eq("b_snap_pre2", 32'(snap_b), 32'h0);
            if (cyc == 74) chk_eq("b_period", 32'(snap_b), 32'h1);
        end

        // Phase 2: enable stall stretches the round; restart overrides pause end.
        do_reset();
        while (cyc < 36) begin
            tick();
            if (cyc == 4) enable = 1'b0;
            if (cyc == 10) begin
                chk_eq("sec_frozen", 32'(sec_a), 32'h1);
                enable = 1'b1;
            end
            if (cyc == 14) chk_eq("sec2", 32'(sec_a), 32'h2);
            if (cyc == 18) begin
                chk_eq("sec3_late", 32'(sec_a), 32'h3);
                chk_eq("tu_late_pre", 32'(tu_a), 32'h0);
            end
            if (cyc == 19) chk_eq("tu_late", 32'(tu_a), 32'h1);
            if (cyc == 22) restart = 1'b1;
            if (cyc == 23) begin
                restart = 1'b0;
                chk_eq("rs_nores", 32'(res_a), 32'h0);
                chk_eq("rs_tu", 32'(tu_a), 32'h0);
                chk_eq("rs_sec", 32'(sec_a), 32'h0);
                chk_eq("rs_rc", 32'(rc_a), 32'h0);
            end
            if (cyc == 35) chk_eq("rs_tu_pre", 32'(tu_a), 32'h0);
            if (cyc == 36) chk_eq("rs_tu_rise", 32'(tu_a), 32'h1);
        end

        // Phase 3: asynchronous reset while A is in CAPTURE and PAUSE.
        #2;
        reset = 1'b0;
        #1;
        chk_eq("ar_addr",  rd_addr_a, 32'h6000);
        chk_eq("ar_lives", 32'(lives_a), 32'h0);
        chk_eq("ar_pos",   32'(pos_a), 32'h0);
        chk_eq("ar_door",  32'(door_a), 32'h0);
        chk_eq("ar_tu",    32'(tu_a), 32'h0);
        chk_eq("ar_sec",   32'(sec_a), 32'h0);
        chk_eq("ar_b_lives", 32'(lives_b), 32'h0);
        do_reset();
        while (cyc < 13) begin
            tick();
            if (cyc == 10) chk_eq("rr_snap_pre", 32'(snap_a), 32'h0);
            if (cyc == 11) begin
                chk_eq("rr_snap", 32'(snap_a), 32'h1);
                chk_eq("rr_lives", 32'(lives_a), 32'h9);
                chk_eq("rr_pos", 32'(pos_a), 32'h3);
                chk_eq("rr_door", 32'(door_a), 32'hC);
            end
            if (cyc == 13) chk_eq("rr_tu", 32'(tu_a), 32'h1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
